// File: rtl/divisor_clk_prog.sv
// ============================================================================
// divisor_clk_prog : programmable synchronous clock divider (tick + square out)
// Optional tick_count output enabled by defining DIVCLK_TICK_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module divisor_clk_prog #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 50000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             tick,
  output logic             out
`ifdef DIVCLK_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pend;

  logic             w_wrap;
  logic             w_load_ok;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W:0]   w_half;
  logic             w_out_next;

  // cur_div is never 0, so cur_div-1 cannot underflow
  assign w_wrap     = (r_cnt == (cur_div - C_ONE));
  assign w_load_ok  = div_load && (div_in != '0);
  assign w_cnt_inc  = r_cnt + C_ONE;
  assign w_half     = ({1'b0, cur_div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
  assign w_out_next = ({1'b0, w_cnt_inc} < w_half);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_pend   <= '0;
      cur_div  <= C_DEF_DIV;
      div_busy <= 1'b0;
      div_err  <= 1'b0;
      tick     <= 1'b0;
      out      <= 1'b0;
    end else begin
      div_err <= div_load && (div_in == '0);
      tick    <= 1'b0;
      if (en) begin
        if (w_wrap) begin
          r_cnt <= '0;
          tick  <= 1'b1;
          out   <= 1'b1;
          if (div_busy) begin
            cur_div  <= r_pend;
            div_busy <= 1'b0;
          end
        end else begin
          r_cnt <= w_cnt_inc;
          out   <= w_out_next;
        end
      end else if (div_busy) begin
        cur_div  <= r_pend;
        r_cnt    <= '0;
        out      <= 1'b1;
        div_busy <= 1'b0;
      end
      // A load on the apply edge overrides the busy clear: new value becomes pending
      if (w_load_ok) begin
        r_pend   <= div_in;
        div_busy <= 1'b1;
      end
    end
  end

`ifdef DIVCLK_TICK_COUNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_count <= 16'h0000;
    end else if (en && w_wrap) begin
      tick_count <= tick_count + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_divisor_clk_prog.sv
// ============================================================================
// tb_divisor_clk_prog : directed patterns plus randomized run vs period model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_divisor_clk_prog;

  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic [CNT_W-1:0] cur_div;
  logic             tick;
  logic             out;
`ifdef DIVCLK_TICK_COUNT_EN
  logic [15:0]      tick_count;
`endif

  int checks = 0;
  int errors = 0;

  divisor_clk_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_err  (div_err),
    .cur_div  (cur_div),
    .tick     (tick),
    .out      (out)
`ifdef DIVCLK_TICK_COUNT_EN
    ,
    .tick_count (tick_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: position within the current period, divisor in effect, pending slot
  int m_phase, m_div, m_pend, m_tc;
  bit m_has, m_tick, m_out, m_err;

  task automatic model_reset();
    m_phase = 0; m_div = DEF_DIV; m_pend = 0; m_has = 0;
    m_tick = 0; m_out = 0; m_err = 0; m_tc = 0;
  endtask

  task automatic model_step();
    m_err  = div_load && (div_in == 0);
    m_tick = 0;
    if (en) begin
      m_phase = (m_phase + 1) % m_div;
      if (m_phase == 0) begin
        m_tick = 1;
        m_tc   = (m_tc + 1) % 65536;
        if (m_has) begin m_div = m_pend; m_has = 0; end
      end
      m_out = (m_phase < (m_div + 1) / 2);
    end else if (m_has) begin
      m_div = m_pend; m_has = 0; m_phase = 0; m_out = 1;
    end
    if (div_load && div_in != 0) begin m_pend = int'(div_in); m_has = 1; end
  endtask

  task automatic check_all();
    chk("tick", tick, m_tick);
    chk("out", out, m_out);
    chk("cur_div", cur_div, m_div);
    chk("div_busy", div_busy, m_has);
    chk("div_err", div_err, m_err);
`ifdef DIVCLK_TICK_COUNT_EN
    chk("tick_count", tick_count, m_tc);
`endif
  endtask

  // Load n, wait for it to take effect, then check two full periods of tick/out
  task automatic run_pattern(input int n);
    bit found;
    found = 0;
    @(negedge clk);
    div_in = CNT_W'(n); div_load = 1; en = 1;
    @(negedge clk);
    div_load = 0;
    for (int k = 0; k < 64; k++) begin
      if (tick && !div_busy) begin found = 1; break; end
      @(negedge clk);
    end
    chk("apply_seen", found, 1);
    chk("pat_cur_div", cur_div, n);
    for (int idx = 0; idx < 2 * n; idx++) begin
      chk("pat_tick", tick, (idx % n) == 0);
      chk("pat_out", out, (idx % n) < (n + 1) / 2);
      @(negedge clk);
    end
  endtask

  initial begin
    rstn = 0; en = 0; div_load = 0; div_in = '0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rstn = 1;

    run_pattern(4);
    run_pattern(5);
    run_pattern(1);

    // Zero divisor rejected
    div_in = '0; div_load = 1;
    @(negedge clk);
    div_load = 0;
    chk("err_pulse", div_err, 1);
    chk("err_cur_div", cur_div, 1);
    chk("err_busy", div_busy, 0);
    @(negedge clk);
    chk("err_clear", div_err, 0);

    // Freeze at phase 5 of 8, then resume and finish the same period
    run_pattern(8);
    repeat (5) @(negedge clk);
    en = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_tick", tick, 0);
      chk("hold_out", out, 0);
    end
    en = 1;
    @(negedge clk); chk("resume6_tick", tick, 0);
    @(negedge clk); chk("resume7_tick", tick, 0);
    @(negedge clk); chk("resume_wrap_tick", tick, 1);
    chk("resume_wrap_out", out, 1);

    // Asynchronous reset takes effect without a clock edge
    #2 rstn = 0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_out", out, 0);
    chk("arst_busy", div_busy, 0);
    chk("arst_err", div_err, 0);
    chk("arst_cur_div", cur_div, DEF_DIV);
    en = 0; div_load = 0;
    @(negedge clk);
    rstn = 1;
    model_reset();

    for (int i = 0; i < 3000; i++) begin
      check_all();
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 11) == 0);
      div_in   = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 9));
      model_step();
      @(negedge clk);
    end
    check_all();

`ifdef DIVCLK_TICK_COUNT_EN
    div_in = 16'd1; div_load = 1; en = 1;
    model_step();
    @(negedge clk);
    div_load = 0;
    for (int i = 0; i < 65600; i++) begin
      chk("tc_run", tick_count, m_tc);
      model_step();
      @(negedge clk);
    end
    check_all();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
